// File: rtl/ray_sphere_hit.sv
// Ray/sphere intersection test for one camera ray per handshake, all products on one shared multiplier.
// Latency: result visible 15 cycles after the accept cycle (SUB 1, MUL 12, DECIDE 1); one ray per 16 cycles minimum.
// Backpressure: ray_ready only in IDLE; the result is held in OUT until hit_ready. Optional macro RAY_HIT_STATS_EN adds hit/ray counters.
module ray_sphere_hit #(
    parameter int DIR_W = 16,
    parameter int POS_W = 11,
    parameter int PIX_W = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ray_valid,
    output logic             ray_ready,
    input  logic [31:0]      ray_dir_x,
    input  logic [31:0]      ray_dir_y,
    input  logic [31:0]      ray_dir_z,
    input  logic [POS_W-1:0] cam_x,
    input  logic [POS_W-1:0] cam_y,
    input  logic [POS_W-1:0] cam_z,
    input  logic [POS_W-1:0] sph_x,
    input  logic [POS_W-1:0] sph_y,
    input  logic [POS_W-1:0] sph_z,
    input  logic [POS_W-1:0] sph_r,
    input  logic [PIX_W-1:0] frame_pixels,
`ifdef RAY_HIT_STATS_EN
    output logic [31:0]      hit_count,
    output logic [31:0]      ray_count,
`endif
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic             hit,
    output logic [PIX_W-1:0] pixel_idx,
    output logic             frame_last
);

    // Operand width covers the widest factor: the 34-bit unsigned a plus a sign bit.
    localparam int OP_W = 35;

    typedef enum logic [2:0] {IDLE, SUB, MUL, DECIDE, OUT} state_t;

    state_t                  state;
    logic [3:0]              k;
    logic signed [DIR_W-1:0] d_x, d_y, d_z;
    logic [POS_W-1:0]        cx, cy, cz, sx, sy, sz, rad;
    logic [PIX_W-1:0]        fp;
    logic signed [POS_W:0]   oc_x, oc_y, oc_z;
    logic [33:0]             acc_a;
    logic signed [29:0]      acc_b;
    logic signed [25:0]      acc_c;
    logic signed [63:0]      p, q;

    logic signed [OP_W-1:0]   mul_x, mul_y;
    logic signed [2*OP_W-1:0] prod;
    logic signed [63:0]       disc;
    logic                     hit_next;
    logic [PIX_W-1:0]         fp_last;

    // Only the low DIR_W bits of each direction component carry information.
    logic unused_dir;
    assign unused_dir = ^{ray_dir_x[31:DIR_W], ray_dir_y[31:DIR_W], ray_dir_z[31:DIR_W]};

    // Operand selection for the shared multiplier, one product per MUL step.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (k)
            4'd0:    begin mul_x = OP_W'(d_x);  mul_y = OP_W'(d_x); end
            4'd1:    begin mul_x = OP_W'(d_y);  mul_y = OP_W'(d_y); end
            4'd2:    begin mul_x = OP_W'(d_z);  mul_y = OP_W'(d_z); end
            4'd3:    begin mul_x = OP_W'(oc_x); mul_y = OP_W'(d_x); end
            4'd4:    begin mul_x = OP_W'(oc_y); mul_y = OP_W'(d_y); end
            4'd5:    begin mul_x = OP_W'(oc_z); mul_y = OP_W'(d_z); end
            4'd6:    begin mul_x = OP_W'(oc_x); mul_y = OP_W'(oc_x); end
            4'd7:    begin mul_x = OP_W'(oc_y); mul_y = OP_W'(oc_y); end
            4'd8:    begin mul_x = OP_W'(oc_z); mul_y = OP_W'(oc_z); end
            4'd9:    begin mul_x = OP_W'({1'b0, rad}); mul_y = OP_W'({1'b0, rad}); end
            4'd10:   begin mul_x = OP_W'(acc_b); mul_y = OP_W'(acc_b); end
            4'd11:   begin mul_x = {1'b0, acc_a}; mul_y = OP_W'(acc_c); end
            default: begin mul_x = '0; mul_y = '0; end
        endcase
    end

    assign prod = mul_x * mul_y;

    // Discriminant test: a hit needs a real root and the sphere not entirely behind the camera.
    always_comb begin
        disc     = p - q;
        hit_next = (disc >= 64'sd0) && (acc_b < 30'sd0 || acc_c < 26'sd0);
        fp_last  = fp - PIX_W'(1);
    end

    // Control FSM with datapath accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ray_ready  <= 1'b1;
            hit_valid  <= 1'b0;
            hit        <= 1'b0;
            pixel_idx  <= '0;
            frame_last <= 1'b0;
            k          <= '0;
            d_x        <= '0;
            d_y        <= '0;
            d_z        <= '0;
            cx         <= '0;
            cy         <= '0;
            cz         <= '0;
            sx         <= '0;
            sy         <= '0;
            sz         <= '0;
            rad        <= '0;
            fp         <= '0;
            oc_x       <= '0;
            oc_y       <= '0;
            oc_z       <= '0;
            acc_a      <= '0;
            acc_b      <= '0;
            acc_c      <= '0;
            p          <= '0;
            q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ray_valid && ray_ready) begin
                        d_x       <= ray_dir_x[DIR_W-1:0];
                        d_y       <= ray_dir_y[DIR_W-1:0];
                        d_z       <= ray_dir_z[DIR_W-1:0];
                        cx        <= cam_x;
                        cy        <= cam_y;
                        cz        <= cam_z;
                        sx        <= sph_x;
                        sy        <= sph_y;
                        sz        <= sph_z;
                        rad       <= sph_r;
                        fp        <= frame_pixels;
                        ray_ready <= 1'b0;
                        state     <= SUB;
                    end
                end
                SUB: begin
                    oc_x  <= $signed({1'b0, cx}) - $signed({1'b0, sx});
                    oc_y  <= $signed({1'b0, cy}) - $signed({1'b0, sy});
                    oc_z  <= $signed({1'b0, cz}) - $signed({1'b0, sz});
                    acc_a <= '0;
                    acc_b <= '0;
                    acc_c <= '0;
                    p     <= '0;
                    q     <= '0;
                    k     <= '0;
                    state <= MUL;
                end
                MUL: begin
                    case (k)
                        4'd0, 4'd1, 4'd2: acc_a <= acc_a + prod[33:0];
                        4'd3, 4'd4, 4'd5: acc_b <= acc_b + prod[29:0];
                        4'd6, 4'd7, 4'd8: acc_c <= acc_c + prod[25:0];
                        4'd9:             acc_c <= acc_c - prod[25:0];
                        4'd10:            p     <= prod[63:0];
                        default:          q     <= prod[63:0];
                    endcase
                    if (k == 4'd11) begin
                        k     <= '0;
                        state <= DECIDE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DECIDE: begin
                    hit        <= hit_next;
                    frame_last <= (pixel_idx == fp_last);
                    hit_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (hit_ready) begin
                        hit_valid  <= 1'b0;
                        frame_last <= 1'b0;
                        ray_ready  <= 1'b1;
                        // A shrunken frame size also forces the wrap.
                        pixel_idx  <= (pixel_idx >= fp_last) ? '0 : pixel_idx + PIX_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ray_ready <= 1'b1;
                    hit_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAY_HIT_STATS_EN
    // Statistics counters advance on each output handshake and wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count <= '0;
            ray_count <= '0;
        end else if (hit_valid && hit_ready) begin
            ray_count <= ray_count + 32'd1;
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ray_sphere_hit.sv
// Directed bench for ray_sphere_hit: hand-computed hit/miss scenes, latency, backpressure, pixel wrap and reset abort.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Each result is held for a configurable number of stall cycles before hit_ready is raised.
module tb_ray_sphere_hit;

    localparam int PIX_W = 26;
    localparam int POS_W = 11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ray_valid;
    logic             ray_ready;
    logic [31:0]      ray_dir_x, ray_dir_y, ray_dir_z;
    logic [POS_W-1:0] cam_x, cam_y, cam_z;
    logic [POS_W-1:0] sph_x, sph_y, sph_z, sph_r;
    logic [PIX_W-1:0] frame_pixels;
    logic             hit_valid;
    logic             hit_ready;
    logic             hit;
    logic [PIX_W-1:0] pixel_idx;
    logic             frame_last;
`ifdef RAY_HIT_STATS_EN
    logic [31:0]      hit_count, ray_count;
`endif

    int checks = 0;
    int errors = 0;

    ray_sphere_hit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ray_valid    (ray_valid),
        .ray_ready    (ray_ready),
        .ray_dir_x    (ray_dir_x),
        .ray_dir_y    (ray_dir_y),
        .ray_dir_z    (ray_dir_z),
        .cam_x        (cam_x),
        .cam_y        (cam_y),
        .cam_z        (cam_z),
        .sph_x        (sph_x),
        .sph_y        (sph_y),
        .sph_z        (sph_z),
        .sph_r        (sph_r),
        .frame_pixels (frame_pixels),
`ifdef RAY_HIT_STATS_EN
        .hit_count    (hit_count),
        .ray_count    (ray_count),
`endif
        .hit_valid    (hit_valid),
        .hit_ready    (hit_ready),
        .hit          (hit),
        .pixel_idx    (pixel_idx),
        .frame_last   (frame_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a ray and return just after the clock edge that accepts it.
    task automatic accept_ray(input int dx, input int dy, input int dz);
        int n;
        ray_valid = 1'b1;
        ray_dir_x = dx;
        ray_dir_y = dy;
        ray_dir_z = dz;
        n = 0;
        while (!ray_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 64'(ray_ready), 64'd1);
        @(posedge clk);
        #1;
        ray_valid = 1'b0;
        // Garbage on the direction bus while busy must not affect the result.
        ray_dir_x = 32'h7FFF_1234;
        ray_dir_y = 32'h8000_5A5A;
        ray_dir_z = 32'h1234_0001;
    endtask

    // Wait for the result, hold it under backpressure for 'stall' cycles, then handshake.
    task automatic collect(input int stall, output logic h, output logic [PIX_W-1:0] idx,
                           output logic last, output int lat);
        @(negedge clk);
        lat = 1;
        while (!hit_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        h    = hit;
        idx  = pixel_idx;
        last = frame_last;
        for (int i = 0; i < stall; i++) begin
            check("stall_hit_valid", 64'(hit_valid), 64'd1);
            check("stall_hit", 64'(hit), 64'(h));
            check("stall_pixel_idx", 64'(pixel_idx), 64'(idx));
            check("stall_frame_last", 64'(frame_last), 64'(last));
            check("stall_ray_ready", 64'(ray_ready), 64'd0);
            @(negedge clk);
        end
        hit_ready = 1'b1;
        @(negedge clk);
        hit_ready = 1'b0;
        check("post_hs_hit_valid", 64'(hit_valid), 64'd0);
        check("post_hs_ray_ready", 64'(ray_ready), 64'd1);
    endtask

    task automatic run_ray(input string tag, input int dx, input int dy, input int dz, input int stall,
                           input logic exp_hit, input logic [PIX_W-1:0] exp_idx, input logic exp_last);
        logic             h;
        logic [PIX_W-1:0] idx;
        logic             last;
        int               lat;
        accept_ray(dx, dy, dz);
        collect(stall, h, idx, last, lat);
        check({tag, "_latency"}, 64'(lat), 64'd15);
        check({tag, "_hit"}, 64'(h), 64'(exp_hit));
        check({tag, "_pixel_idx"}, 64'(idx), 64'(exp_idx));
        check({tag, "_frame_last"}, 64'(last), 64'(exp_last));
    endtask

    initial begin
        int hv_seen;
`ifdef RAY_HIT_STATS_EN
        logic [31:0] rc0, hc0;
`endif
        reset_n      = 1'b0;
        ray_valid    = 1'b0;
        hit_ready    = 1'b0;
        ray_dir_x    = '0;
        ray_dir_y    = '0;
        ray_dir_z    = '0;
        cam_x        = 11'd100;
        cam_y        = 11'd100;
        cam_z        = 11'd0;
        sph_x        = 11'd100;
        sph_y        = 11'd100;
        sph_z        = 11'd50;
        sph_r        = 11'd10;
        frame_pixels = 26'd100;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ray_ready", 64'(ray_ready), 64'd1);
        check("rst_hit_valid", 64'(hit_valid), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_pixel_idx", 64'(pixel_idx), 64'd0);
        check("rst_frame_last", 64'(frame_last), 64'd0);
`ifdef RAY_HIT_STATS_EN
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_ray_count", 64'(ray_count), 64'd0);
`endif

        // Sphere straight ahead: a=2500 b=-2500 c=2400 disc=250000.
        run_ray("ahead", 0, 0, 50, 0, 1'b1, 26'd0, 1'b0);
        // Grazing miss: a=2900 disc=-710000.
        run_ray("miss", 20, 0, 50, 0, 1'b0, 26'd1, 1'b0);
        // Near tangent: a=2600 disc=10000.
        run_ray("tangent", 10, 0, 50, 0, 1'b1, 26'd2, 1'b0);
        // Sphere behind camera: b=+2500, c>0.
        run_ray("behind", 0, 0, -50, 0, 1'b0, 26'd3, 1'b0);
        // Camera inside the sphere: c=-100.
        sph_z = 11'd0;
        run_ray("inside", 1, 0, 0, 0, 1'b1, 26'd4, 1'b0);
        sph_z = 11'd50;

        // Frame shrinks to 3 while pixel_idx is 5: this ray is not last, then the index wraps.
        frame_pixels = 26'd3;
        run_ray("shrink", 0, 0, 50, 0, 1'b1, 26'd5, 1'b0);
        check("shrink_wrap_idx", 64'(pixel_idx), 64'd0);

`ifdef RAY_HIT_STATS_EN
        rc0 = ray_count;
        hc0 = hit_count;
`endif
        // Four rays over a 3-pixel frame, stalling the last-pixel result for 5 cycles.
        run_ray("bp0", 0, 0, 50, 0, 1'b1, 26'd0, 1'b0);
        run_ray("bp1", 20, 0, 50, 0, 1'b0, 26'd1, 1'b0);
        run_ray("bp2", 10, 0, 50, 5, 1'b1, 26'd2, 1'b1);
        run_ray("bp3", 0, 0, -50, 0, 1'b0, 26'd0, 1'b0);
`ifdef RAY_HIT_STATS_EN
        check("stats_ray_delta", 64'(ray_count - rc0), 64'd4);
        check("stats_hit_delta", 64'(hit_count - hc0), 64'd2);
        check("stats_ray_total", 64'(ray_count), 64'd10);
        check("stats_hit_total", 64'(hit_count), 64'd6);
`endif
        check("pre_abort_idx", 64'(pixel_idx), 64'd1);

        // Abort a ray in the middle of the MUL phase.
        accept_ray(0, 0, 50);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_ray_ready", 64'(ray_ready), 64'd1);
        check("abort_hit_valid", 64'(hit_valid), 64'd0);
        check("abort_pixel_idx", 64'(pixel_idx), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        hv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hit_valid) hv_seen++;
        end
        check("abort_no_result", 64'(hv_seen), 64'd0);
        check("abort_idle_ready", 64'(ray_ready), 64'd1);
        run_ray("after_abort", 0, 0, 50, 0, 1'b1, 26'd0, 1'b0);
`ifdef RAY_HIT_STATS_EN
        check("after_abort_ray_count", 64'(ray_count), 64'd1);
        check("after_abort_hit_count", 64'(hit_count), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
